// File: rtl/pcie_tag_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : pcie_tag_arbiter
//  Purpose  : Shares the PCIe read-request tag pool among REQ_CNT DMA read
//             requesters. Pops free tags from the allocator and grants them
//             round-robin. Caps outstanding tags per requester. Records tag
//             ownership so completions can be routed. Returns a tag to the
//             allocator on its last completion beat.
//  Ports    :
//    clk, rst          - clock, synchronous active-high reset
//    cfg_limit         - max outstanding tags per requester (0 blocks grants)
//    stop              - level, suppresses new grants
//    quiesced          - stopped with no tag outstanding (registered)
//    err_unexpected    - sticky, last completion for a non-outstanding tag
//    req_valid/req_ack - per-requester request / one-hot grant pulse
//    grant_tag         - tag granted alongside req_ack
//    t_core_ready      - allocator finished its initial fill
//    t_alloc_*         - allocator pop interface (valid/ready/data)
//    t_free_*          - tag return interface to the allocator
//    s_cpl_*           - completion beat stream (tag/last/valid/ready)
//    m_cpl_owner       - owner of s_cpl_tag, combinational lookup
//  Revision : 1.0 - initial release
// ============================================================================
module pcie_tag_arbiter #(
  parameter int PCIE_TAG_BITS = 5,
  parameter int REQ_CNT       = 4,
  parameter int REQ_BITS      = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [PCIE_TAG_BITS:0]   cfg_limit,
  input  logic                     stop,
  output logic                     quiesced,
  output logic                     err_unexpected,
  input  logic [REQ_CNT-1:0]       req_valid,
  output logic [REQ_CNT-1:0]       req_ack,
  output logic [PCIE_TAG_BITS-1:0] grant_tag,
  input  logic                     t_core_ready,
  input  logic [PCIE_TAG_BITS-1:0] t_alloc_data,
  input  logic                     t_alloc_valid,
  output logic                     t_alloc_ready,
  output logic [PCIE_TAG_BITS-1:0] t_free_data,
  output logic                     t_free_valid,
  input  logic                     t_free_ready,
  input  logic [PCIE_TAG_BITS-1:0] s_cpl_tag,
  input  logic                     s_cpl_last,
  input  logic                     s_cpl_valid,
  output logic                     s_cpl_ready,
  output logic [REQ_BITS-1:0]      m_cpl_owner
);

  localparam int NTAGS = 1 << PCIE_TAG_BITS;
  localparam int CW    = PCIE_TAG_BITS + 1;
  localparam logic [REQ_BITS:0]   REQ_CNT_W = (REQ_BITS+1)'(REQ_CNT);
  localparam logic [REQ_BITS-1:0] REQ_LAST  = REQ_BITS'(REQ_CNT - 1);

  typedef enum logic [1:0] {
    ST_INIT = 2'd0,
    ST_RUN  = 2'd1,
    ST_HOLD = 2'd2
  } state_t;

  state_t              state;
  logic [NTAGS-1:0]    busy;
  logic [REQ_BITS-1:0] owner [NTAGS];
  logic [CW-1:0]       cnt [REQ_CNT];
  logic [REQ_BITS-1:0] rr_ptr;

  // --------------------------------------------------------------------------
  // Arbitration
  // --------------------------------------------------------------------------
  logic [REQ_CNT-1:0]  elig;
  logic [REQ_BITS:0]   scan_idx;
  logic                found;
  logic [REQ_BITS-1:0] winner;
  logic                pop;
  logic [REQ_BITS-1:0] rr_next;
  logic [REQ_CNT-1:0]  win_onehot;

  // The ack term keeps a requester that is still holding req_valid in the
  // cycle its grant is presented from being granted a second time.
  always_comb begin
    elig = '0;
    for (int i = 0; i < REQ_CNT; i++) begin
      elig[i] = req_valid[i] & ~req_ack[i] & (cnt[i] < cfg_limit);
    end
  end

  // First eligible index at or after rr_ptr, wrapping modulo REQ_CNT.
  always_comb begin
    found    = 1'b0;
    winner   = '0;
    scan_idx = '0;
    for (int k = 0; k < REQ_CNT; k++) begin
      scan_idx = {1'b0, rr_ptr} + (REQ_BITS+1)'(k);
      if (scan_idx >= REQ_CNT_W) begin
        scan_idx = scan_idx - REQ_CNT_W;
      end
      if (!found && elig[scan_idx[REQ_BITS-1:0]]) begin
        found  = 1'b1;
        winner = scan_idx[REQ_BITS-1:0];
      end
    end
  end

  // stop is honoured combinationally so no pop happens in the cycle it rises.
  assign pop           = !rst && (state == ST_RUN) && !stop && t_alloc_valid && found;
  assign t_alloc_ready = pop;
  assign rr_next       = (winner == REQ_LAST) ? '0 : winner + 1'b1;
  assign win_onehot    = REQ_CNT'(1) << winner;

  // --------------------------------------------------------------------------
  // Completion routing and tag return
  // --------------------------------------------------------------------------
  logic                cpl_busy;
  logic                cpl_last_beat;
  logic                free_fire;
  logic                unexpected;
  logic [REQ_BITS-1:0] free_owner;
  logic [NTAGS-1:0]    busy_set;
  logic [NTAGS-1:0]    busy_clr;

  assign cpl_busy      = busy[s_cpl_tag];
  assign cpl_last_beat = s_cpl_valid && s_cpl_last;
  assign t_free_valid  = !rst && cpl_last_beat && cpl_busy;
  assign t_free_data   = s_cpl_tag;
  // Only a last beat for an outstanding tag can be back-pressured by the
  // allocator; everything else (data beats, stray last beats) is accepted.
  assign s_cpl_ready   = (s_cpl_last && cpl_busy) ? t_free_ready : 1'b1;
  assign free_fire     = t_free_valid && t_free_ready;
  assign unexpected    = cpl_last_beat && !cpl_busy;
  assign m_cpl_owner   = owner[s_cpl_tag];
  assign free_owner    = owner[s_cpl_tag];

  // An allocated tag is never busy, so set and clear never hit the same bit.
  assign busy_set = pop       ? (NTAGS'(1) << t_alloc_data) : '0;
  assign busy_clr = free_fire ? (NTAGS'(1) << s_cpl_tag)    : '0;

  // --------------------------------------------------------------------------
  // State machine, tag tables and registered outputs
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= ST_INIT;
      req_ack        <= '0;
      grant_tag      <= '0;
      quiesced       <= 1'b0;
      err_unexpected <= 1'b0;
      rr_ptr         <= '0;
      busy           <= '0;
      for (int t = 0; t < NTAGS; t++) begin
        owner[t] <= '0;
      end
      for (int i = 0; i < REQ_CNT; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      case (state)
        ST_INIT: if (t_core_ready) state <= ST_RUN;
        ST_RUN:  if (stop)         state <= ST_HOLD;
        ST_HOLD: if (!stop)        state <= ST_RUN;
        default:                   state <= ST_INIT;
      endcase

      quiesced <= (state == ST_HOLD) && (busy == '0);

      if (pop) begin
        req_ack             <= win_onehot;
        grant_tag           <= t_alloc_data;
        owner[t_alloc_data] <= winner;
        rr_ptr              <= rr_next;
      end else begin
        req_ack <= '0;
      end

      busy <= (busy | busy_set) & ~busy_clr;

      // Alloc and free for the same requester in one cycle cancel out.
      for (int i = 0; i < REQ_CNT; i++) begin
        if ((pop && winner == REQ_BITS'(i)) && !(free_fire && free_owner == REQ_BITS'(i))) begin
          cnt[i] <= cnt[i] + 1'b1;
        end else if (!(pop && winner == REQ_BITS'(i)) && (free_fire && free_owner == REQ_BITS'(i))) begin
          cnt[i] <= cnt[i] - 1'b1;
        end
      end

      if (unexpected) begin
        err_unexpected <= 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_pcie_tag_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pcie_tag_arbiter
//  Purpose  : Self-checking bench for pcie_tag_arbiter. The bench plays the
//             tag allocator (a queue of free tags) and keeps a behavioural
//             model of tag ownership, per-requester counts and grants.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_pcie_tag_arbiter;

  localparam int NR = 4;
  localparam int NT = 32;

  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] cfg_limit;
  logic       stop;
  logic       quiesced, err_unexpected;
  logic [3:0] req_valid, req_ack;
  logic [4:0] grant_tag;
  logic       t_core_ready;
  logic [4:0] t_alloc_data;
  logic       t_alloc_valid, t_alloc_ready;
  logic [4:0] t_free_data;
  logic       t_free_valid, t_free_ready;
  logic [4:0] s_cpl_tag;
  logic       s_cpl_last, s_cpl_valid, s_cpl_ready;
  logic [1:0] m_cpl_owner;

  always #5 clk = ~clk;

  pcie_tag_arbiter #(.PCIE_TAG_BITS(5), .REQ_CNT(4), .REQ_BITS(2)) dut (
    .clk(clk), .rst(rst), .cfg_limit(cfg_limit), .stop(stop),
    .quiesced(quiesced), .err_unexpected(err_unexpected),
    .req_valid(req_valid), .req_ack(req_ack), .grant_tag(grant_tag),
    .t_core_ready(t_core_ready), .t_alloc_data(t_alloc_data),
    .t_alloc_valid(t_alloc_valid), .t_alloc_ready(t_alloc_ready),
    .t_free_data(t_free_data), .t_free_valid(t_free_valid), .t_free_ready(t_free_ready),
    .s_cpl_tag(s_cpl_tag), .s_cpl_last(s_cpl_last), .s_cpl_valid(s_cpl_valid),
    .s_cpl_ready(s_cpl_ready), .m_cpl_owner(m_cpl_owner)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: free-tag queue, outstanding set, owners, counts.
  int         free_q[$];
  bit         m_busy[NT];
  int         m_owner[NT];
  int         m_cnt[NR];
  int         m_rr;
  int         m_mode;      // 0 = waiting for allocator, 1 = granting, 2 = held
  bit         m_err, m_quiesced;
  logic [3:0] m_ack;
  logic [4:0] m_tag;
  bit         alloc_en;
  bit         exp_pop, exp_free_valid, exp_cpl_ready, exp_fire, exp_unexp;
  int         exp_win;

  task automatic model_reset();
    free_q.delete();
    for (int t = 0; t < NT; t++) begin
      free_q.push_back(t);
      m_busy[t]  = 1'b0;
      m_owner[t] = 0;
    end
    for (int i = 0; i < NR; i++) m_cnt[i] = 0;
    m_rr = 0; m_mode = 0; m_err = 0; m_quiesced = 0; m_ack = '0; m_tag = '0;
  endtask

  // Drive the allocator from the model queue, let the DUT settle, and work
  // out what should happen in this cycle.
  task automatic settle();
    t_alloc_valid = alloc_en && (free_q.size() > 0);
    t_alloc_data  = (free_q.size() > 0) ? 5'(free_q[0]) : 5'd0;
    #1;
    exp_pop = 1'b0;
    exp_win = 0;
    if (m_mode == 1 && !stop && t_alloc_valid) begin
      for (int k = 0; k < NR; k++) begin
        int i;
        i = (m_rr + k) % NR;
        if (!exp_pop && req_valid[i] && !m_ack[i] && m_cnt[i] < int'(cfg_limit)) begin
          exp_pop = 1'b1;
          exp_win = i;
        end
      end
    end
    exp_free_valid = s_cpl_valid && s_cpl_last && m_busy[s_cpl_tag];
    exp_cpl_ready  = (s_cpl_last && m_busy[s_cpl_tag]) ? t_free_ready : 1'b1;
    exp_fire       = exp_free_valid && t_free_ready;
    exp_unexp      = s_cpl_valid && s_cpl_last && !m_busy[s_cpl_tag];
  endtask

  // Clock edge: commit the model, then return at the falling edge.
  task automatic tick();
    bit any_busy;
    int tag;
    @(posedge clk);
    any_busy = 1'b0;
    for (int t = 0; t < NT; t++) any_busy |= m_busy[t];
    m_quiesced = (m_mode == 2) && !any_busy;
    if (exp_pop) begin
      tag = free_q.pop_front();
      m_busy[tag]  = 1'b1;
      m_owner[tag] = exp_win;
      m_cnt[exp_win]++;
      m_rr  = (exp_win + 1) % NR;
      m_ack = 4'(1 << exp_win);
      m_tag = 5'(tag);
    end else begin
      m_ack = '0;
    end
    if (exp_fire) begin
      m_busy[s_cpl_tag] = 1'b0;
      m_cnt[m_owner[s_cpl_tag]]--;
      free_q.push_back(int'(s_cpl_tag));
    end
    if (exp_unexp) m_err = 1'b1;
    case (m_mode)
      0: if (t_core_ready) m_mode = 1;
      1: if (stop)         m_mode = 2;
      default: if (!stop)  m_mode = 1;
    endcase
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1; stop = 1'b0; req_valid = '0; cfg_limit = 6'd8;
    s_cpl_valid = 1'b0; s_cpl_last = 1'b0; s_cpl_tag = '0; t_free_ready = 1'b1;
    t_core_ready = 1'b0; alloc_en = 1'b1; t_alloc_valid = 1'b0; t_alloc_data = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    do_reset();
    settle();
    checks++; if (req_ack !== 4'd0) begin errors++; $display("FAIL reset_ack actual=%b required=0000", req_ack); end
    checks++; if (grant_tag !== 5'd0) begin errors++; $display("FAIL reset_tag actual=%0d required=0", grant_tag); end
    checks++; if (t_alloc_ready !== 1'b0) begin errors++; $display("FAIL reset_alloc_ready actual=%b required=0", t_alloc_ready); end
    checks++; if (t_free_valid !== 1'b0) begin errors++; $display("FAIL reset_free_valid actual=%b required=0", t_free_valid); end
    checks++; if (quiesced !== 1'b0) begin errors++; $display("FAIL reset_quiesced actual=%b required=0", quiesced); end
    checks++; if (err_unexpected !== 1'b0) begin errors++; $display("FAIL reset_err actual=%b required=0", err_unexpected); end
  endtask

  task automatic test_init();
    bit bad;
    bit got;
    do_reset();
    req_valid = 4'hF;
    bad = 1'b0;
    for (int c = 0; c < 32; c++) begin
      settle();
      if (t_alloc_ready !== 1'b0 || req_ack !== 4'd0) bad = 1'b1;
      tick();
    end
    checks++; if (bad) begin errors++; $display("FAIL init_idle actual=grant_seen required=no_grant"); end
    t_core_ready = 1'b1;
    got = 1'b0;
    for (int c = 0; c < 6 && !got; c++) begin
      settle(); tick();
      if (req_ack !== 4'd0) got = 1'b1;
    end
    checks++; if (!got) begin errors++; $display("FAIL init_first_grant actual=timeout required=ack"); end
    checks++; if (req_ack !== 4'b0001) begin errors++; $display("FAIL init_ack actual=%b required=0001", req_ack); end
    checks++; if (grant_tag !== 5'd0) begin errors++; $display("FAIL init_tag actual=%0d required=0", grant_tag); end
  endtask

  task automatic test_round_robin();
    int n;
    logic [3:0] prev;
    do_reset();
    t_core_ready = 1'b1; cfg_limit = 6'd8; req_valid = 4'hF;
    n = 0; prev = '0;
    for (int c = 0; c < 60 && n < 16; c++) begin
      settle(); tick();
      if (req_ack !== 4'd0) begin
        checks++; if (req_ack !== 4'(1 << (n % 4))) begin errors++; $display("FAIL rr_order grant=%0d actual=%b required=%b", n, req_ack, 4'(1 << (n % 4))); end
        checks++; if (grant_tag !== 5'(n)) begin errors++; $display("FAIL rr_tag grant=%0d actual=%0d required=%0d", n, grant_tag, n); end
        checks++; if ((req_ack & prev) !== 4'd0) begin errors++; $display("FAIL rr_back_to_back actual=%b previous=%b required=disjoint", req_ack, prev); end
        n++;
      end
      prev = req_ack;
    end
    checks++; if (n != 16) begin errors++; $display("FAIL rr_count actual=%0d required=16", n); end
    req_valid = '0;
  endtask

  task automatic test_limit();
    int n;
    bit got;
    do_reset();
    t_core_ready = 1'b1; cfg_limit = 6'd2; req_valid = 4'b0100;
    n = 0;
    for (int c = 0; c < 14; c++) begin
      settle(); tick();
      if (req_ack !== 4'd0) begin
        checks++; if (req_ack !== 4'b0100 || grant_tag !== 5'(n)) begin errors++; $display("FAIL limit_grant actual=%b/%0d required=0100/%0d", req_ack, grant_tag, n); end
        n++;
      end
    end
    checks++; if (n != 2) begin errors++; $display("FAIL limit_count actual=%0d required=2", n); end
    s_cpl_valid = 1'b1; s_cpl_last = 1'b1; s_cpl_tag = 5'd0; t_free_ready = 1'b1;
    settle();
    checks++; if (t_free_valid !== 1'b1 || t_free_data !== 5'd0) begin errors++; $display("FAIL limit_free actual=%b/%0d required=1/0", t_free_valid, t_free_data); end
    checks++; if (m_cpl_owner !== 2'd2) begin errors++; $display("FAIL limit_owner actual=%0d required=2", m_cpl_owner); end
    checks++; if (s_cpl_ready !== 1'b1) begin errors++; $display("FAIL limit_cpl_ready actual=%b required=1", s_cpl_ready); end
    tick();
    s_cpl_valid = 1'b0; s_cpl_last = 1'b0;
    got = 1'b0;
    for (int c = 0; c < 6 && !got; c++) begin
      settle(); tick();
      if (req_ack !== 4'd0) got = 1'b1;
    end
    checks++; if (!got || req_ack !== 4'b0100 || grant_tag !== 5'd2) begin errors++; $display("FAIL limit_third actual=%b/%0d required=0100/2", req_ack, grant_tag); end
    req_valid = '0;
  endtask

  task automatic test_exhaustion();
    int n;
    bit bad, got;
    do_reset();
    t_core_ready = 1'b1; cfg_limit = 6'd32; req_valid = 4'b0001;
    n = 0;
    for (int c = 0; c < 80 && n < 32; c++) begin
      settle(); tick();
      if (req_ack !== 4'd0) begin
        checks++; if (grant_tag !== 5'(n)) begin errors++; $display("FAIL exh_tag actual=%0d required=%0d", grant_tag, n); end
        n++;
      end
    end
    checks++; if (n != 32) begin errors++; $display("FAIL exh_count actual=%0d required=32", n); end
    bad = 1'b0;
    for (int c = 0; c < 6; c++) begin
      settle();
      if (t_alloc_ready !== 1'b0) bad = 1'b1;
      tick();
      if (req_ack !== 4'd0) bad = 1'b1;
    end
    checks++; if (bad) begin errors++; $display("FAIL exh_stall actual=grant required=none"); end
    s_cpl_valid = 1'b1; s_cpl_last = 1'b1; s_cpl_tag = 5'd7;
    settle();
    checks++; if (t_free_valid !== 1'b1 || m_cpl_owner !== 2'd0) begin errors++; $display("FAIL exh_free actual=%b/%0d required=1/0", t_free_valid, m_cpl_owner); end
    tick();
    s_cpl_valid = 1'b0; s_cpl_last = 1'b0;
    got = 1'b0;
    for (int c = 0; c < 6 && !got; c++) begin
      settle(); tick();
      if (req_ack !== 4'd0) got = 1'b1;
    end
    checks++; if (!got || grant_tag !== 5'd7) begin errors++; $display("FAIL exh_reuse actual=%0d required=7", grant_tag); end
    req_valid = '0;
  endtask

  task automatic test_unexpected();
    do_reset();
    t_core_ready = 1'b1;
    settle(); tick();
    s_cpl_valid = 1'b1; s_cpl_last = 1'b1; s_cpl_tag = 5'd9; t_free_ready = 1'b1;
    settle();
    checks++; if (s_cpl_ready !== 1'b1) begin errors++; $display("FAIL unexp_ready actual=%b required=1", s_cpl_ready); end
    checks++; if (t_free_valid !== 1'b0) begin errors++; $display("FAIL unexp_free actual=%b required=0", t_free_valid); end
    checks++; if (err_unexpected !== 1'b0) begin errors++; $display("FAIL unexp_early actual=%b required=0", err_unexpected); end
    tick();
    s_cpl_valid = 1'b0; s_cpl_last = 1'b0;
    checks++; if (err_unexpected !== 1'b1) begin errors++; $display("FAIL unexp_set actual=%b required=1", err_unexpected); end
    repeat (5) begin settle(); tick(); end
    checks++; if (err_unexpected !== 1'b1) begin errors++; $display("FAIL unexp_sticky actual=%b required=1", err_unexpected); end
  endtask

  task automatic test_quiesce();
    int n;
    bit bad, got;
    do_reset();
    t_core_ready = 1'b1; cfg_limit = 6'd8; req_valid = 4'b0001;
    n = 0;
    for (int c = 0; c < 12 && n < 2; c++) begin
      settle(); tick();
      if (req_ack !== 4'd0) n++;
    end
    req_valid = '0;
    repeat (2) begin settle(); tick(); end
    // Requester 0 gets a new tag in the same cycle one of its tags is freed.
    req_valid = 4'b0001; s_cpl_valid = 1'b1; s_cpl_last = 1'b1; s_cpl_tag = 5'd0;
    settle();
    checks++; if (t_alloc_ready !== 1'b1 || t_free_valid !== 1'b1) begin errors++; $display("FAIL sim_both actual=%b/%b required=1/1", t_alloc_ready, t_free_valid); end
    tick();
    req_valid = '0; s_cpl_valid = 1'b0; s_cpl_last = 1'b0;
    settle(); tick();
    // Two tags outstanding; a limit of 3 must allow exactly one more.
    cfg_limit = 6'd3; req_valid = 4'b0001; n = 0;
    for (int c = 0; c < 10; c++) begin
      settle(); tick();
      if (req_ack !== 4'd0) n++;
    end
    checks++; if (n != 1) begin errors++; $display("FAIL sim_cnt_kept actual=%0d required=1", n); end
    cfg_limit = 6'd8; stop = 1'b1;
    settle();
    checks++; if (t_alloc_ready !== 1'b0) begin errors++; $display("FAIL stop_same_cycle actual=%b required=0", t_alloc_ready); end
    tick();
    req_valid = '0;
    settle(); tick();
    for (int t = 1; t <= 2; t++) begin
      s_cpl_valid = 1'b1; s_cpl_last = 1'b1; s_cpl_tag = 5'(t);
      settle();
      checks++; if (t_free_valid !== 1'b1 || m_cpl_owner !== 2'd0) begin errors++; $display("FAIL hold_free tag=%0d actual=%b/%0d required=1/0", t, t_free_valid, m_cpl_owner); end
      tick();
    end
    s_cpl_tag = 5'd3; t_free_ready = 1'b0; bad = 1'b0;
    for (int c = 0; c < 3; c++) begin
      settle();
      if (s_cpl_ready !== 1'b0 || t_free_valid !== 1'b1) bad = 1'b1;
      tick();
      if (quiesced !== 1'b0) bad = 1'b1;
    end
    checks++; if (bad) begin errors++; $display("FAIL free_stall actual=not_stalled required=stalled"); end
    t_free_ready = 1'b1;
    settle();
    checks++; if (s_cpl_ready !== 1'b1) begin errors++; $display("FAIL free_release actual=%b required=1", s_cpl_ready); end
    tick();
    s_cpl_valid = 1'b0; s_cpl_last = 1'b0;
    checks++; if (quiesced !== 1'b0) begin errors++; $display("FAIL quiesce_early actual=%b required=0", quiesced); end
    got = 1'b0;
    for (int c = 0; c < 3 && !got; c++) begin
      settle(); tick();
      if (quiesced === 1'b1) got = 1'b1;
    end
    checks++; if (!got) begin errors++; $display("FAIL quiesce_rise actual=0 required=1"); end
    stop = 1'b0;
  endtask

  task automatic test_random();
    int busy_list[$];
    do_reset();
    t_core_ready = 1'b1;
    for (int c = 0; c < 1500; c++) begin
      if ($urandom_range(0, 19) == 0) cfg_limit = 6'($urandom_range(0, 9));
      if ($urandom_range(0, 39) == 0) stop = ~stop;
      req_valid    = 4'($urandom);
      alloc_en     = ($urandom_range(0, 7) != 0);
      t_free_ready = ($urandom_range(0, 3) != 0);
      busy_list.delete();
      for (int t = 0; t < NT; t++) if (m_busy[t]) busy_list.push_back(t);
      s_cpl_valid = 1'b0; s_cpl_last = 1'b0;
      case ($urandom_range(0, 9))
        0, 1, 2, 3, 4: if (busy_list.size() > 0) begin
          s_cpl_valid = 1'b1;
          s_cpl_tag   = 5'(busy_list[$urandom_range(0, busy_list.size() - 1)]);
          s_cpl_last  = ($urandom_range(0, 2) != 0);
        end
        5: if ($urandom_range(0, 3) == 0) begin
          s_cpl_valid = 1'b1; s_cpl_last = 1'b1; s_cpl_tag = 5'($urandom);
        end
        default: ;
      endcase
      settle();
      checks++; if (t_alloc_ready !== exp_pop) begin errors++; $display("FAIL rnd_alloc cyc=%0d actual=%b required=%b", c, t_alloc_ready, exp_pop); end
      checks++; if (t_free_valid !== exp_free_valid) begin errors++; $display("FAIL rnd_free_valid cyc=%0d actual=%b required=%b", c, t_free_valid, exp_free_valid); end
      checks++; if (s_cpl_ready !== exp_cpl_ready) begin errors++; $display("FAIL rnd_cpl_ready cyc=%0d actual=%b required=%b", c, s_cpl_ready, exp_cpl_ready); end
      if (s_cpl_valid && m_busy[s_cpl_tag]) begin
        checks++; if (m_cpl_owner !== 2'(m_owner[s_cpl_tag])) begin errors++; $display("FAIL rnd_owner cyc=%0d actual=%0d required=%0d", c, m_cpl_owner, m_owner[s_cpl_tag]); end
      end
      if (exp_free_valid) begin
        checks++; if (t_free_data !== s_cpl_tag) begin errors++; $display("FAIL rnd_free_data cyc=%0d actual=%0d required=%0d", c, t_free_data, s_cpl_tag); end
      end
      tick();
      checks++; if (req_ack !== m_ack) begin errors++; $display("FAIL rnd_ack cyc=%0d actual=%b required=%b", c, req_ack, m_ack); end
      if (m_ack != 4'd0) begin
        checks++; if (grant_tag !== m_tag) begin errors++; $display("FAIL rnd_tag cyc=%0d actual=%0d required=%0d", c, grant_tag, m_tag); end
      end
      checks++; if (err_unexpected !== m_err) begin errors++; $display("FAIL rnd_err cyc=%0d actual=%b required=%b", c, err_unexpected, m_err); end
      checks++; if (quiesced !== m_quiesced) begin errors++; $display("FAIL rnd_quiesced cyc=%0d actual=%b required=%b", c, quiesced, m_quiesced); end
    end
    stop = 1'b0; req_valid = '0; s_cpl_valid = 1'b0;
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_init();
    test_round_robin();
    test_limit();
    test_exhaustion();
    test_unexpected();
    test_quiesce();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
